i2c_deb_filter_mc: RTL and testbench

Parametrised multi-channel successor to the two-line SDA/SCL debouncer in the event-save UFM I2C path. Each channel has a two-flop synchroniser, a runtime-programmable persistence threshold, a per-channel force-low override, one-cycle rise/fall strobes and an optional saturating glitch counter. It sits between the CPLD I2C pins and the slave/event-logging logic. It filters any number of open-drain lines (SDA, SCL, SMBALERT#, etc.).

---
 rtl/i2c_deb_filter_mc.sv | 124 ++++++++++++
 tb/tb_i2c_deb_filter_mc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_deb_filter_mc.sv
// i2c_deb_filter_mc: multi-channel debounce filter for open-drain lines
// (SDA, SCL, SMBALERT#, ...). Each channel synchronises its raw line,
// requires a run of thr_i consecutive differing samples before the filtered
// level follows, can be forced low, emits one-cycle rise/fall strobes and
// optionally counts rejected glitches.
// Optional feature macro: I2C_DEB_GLITCH_CNT_EN (builds the saturating
// per-channel glitch counters; when undefined glitch_cnt_o is all zero).
module i2c_deb_filter_mc #(
  parameter int CH    = 2,
  parameter int CNT_W = 4,
  parameter int GC_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CH-1:0]        line_i,
  input  logic [CH-1:0]        force_low_i,
  input  logic [CNT_W-1:0]     thr_i,
  input  logic                 glitch_clr_i,
  output logic [CH-1:0]        line_o,
  output logic [CH-1:0]        rise_o,
  output logic [CH-1:0]        fall_o,
  output logic [CH*GC_W-1:0]   glitch_cnt_o
);

  // Saturating increment of a run counter.
  function automatic logic [CNT_W-1:0] sat_inc_run(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Saturating increment of a glitch counter.
  function automatic logic [GC_W-1:0] sat_inc_gc(input logic [GC_W-1:0] v);
    return (v == {GC_W{1'b1}}) ? v : v + GC_W'(1);
  endfunction

  logic [CNT_W-1:0] thr_eff;

  // A programmed threshold of zero behaves like a threshold of one.
  always_comb begin
    thr_eff = thr_i;
    if (thr_i == '0) thr_eff = CNT_W'(1);
  end

`ifndef I2C_DEB_GLITCH_CNT_EN
  // The clear input has no counters to act on in this build.
  logic glitch_clr_unused;
  assign glitch_clr_unused = glitch_clr_i;
`endif

  for (genvar n = 0; n < CH; n++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             line_q;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] run;
    logic             differs;
    logic [CNT_W:0]   run_plus;
    logic             reached;

    // One extra bit keeps run+1 from wrapping when run is saturated.
    assign differs  = s2 ^ line_q;
    assign run_plus = {1'b0, run} + (CNT_W + 1)'(1);
    assign reached  = run_plus >= {1'b0, thr_eff};

    // Synchroniser, persistence run counter, filtered level and edge strobes.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s1     <= 1'b1;
        s2     <= 1'b1;
        line_q <= 1'b1;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        run    <= '0;
      end else begin
        s1     <= line_i[n];
        s2     <= s1;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (force_low_i[n]) begin
          line_q <= 1'b0;
          run    <= '0;
          fall_q <= line_q;
        end else if (differs) begin
          if (reached) begin
            line_q <= s2;
            run    <= '0;
            rise_q <= s2;
            fall_q <= ~s2;
          end else begin
            run <= sat_inc_run(run);
          end
        end else begin
          run <= '0;
        end
      end
    end

    assign line_o[n] = line_q;
    assign rise_o[n] = rise_q;
    assign fall_o[n] = fall_q;

`ifdef I2C_DEB_GLITCH_CNT_EN
    logic            glitch;
    logic [GC_W-1:0] gcnt;

    // A partial run that ends with the line back at the filtered level is a glitch.
    assign glitch = ~force_low_i[n] & ~differs & (run != '0);

    // Saturating glitch counter; clear wins over a simultaneous increment.
    always_ff @(posedge clk_i) begin
      if (rst_i || glitch_clr_i) begin
        gcnt <= '0;
      end else if (glitch) begin
        gcnt <= sat_inc_gc(gcnt);
      end
    end

    assign glitch_cnt_o[n*GC_W +: GC_W] = gcnt;
`else
    assign glitch_cnt_o[n*GC_W +: GC_W] = '0;
`endif
  end

endmodule

// File: tb/tb_i2c_deb_filter_mc.sv
// Testbench for i2c_deb_filter_mc: directed scenarios plus randomized
// stimulus checked against a behavioural model of the filter rules.
module tb_i2c_deb_filter_mc;
  localparam int CH    = 2;
  localparam int CNT_W = 4;
  localparam int GC_W  = 8;
  localparam int GC_MAX = (1 << GC_W) - 1;
`ifdef I2C_DEB_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [CH-1:0]       line;
  logic [CH-1:0]       force_low;
  logic [CNT_W-1:0]    thr;
  logic                glitch_clr;
  logic [CH-1:0]       line_o;
  logic [CH-1:0]       rise_o;
  logic [CH-1:0]       fall_o;
  logic [CH*GC_W-1:0]  glitch_cnt;

  int total = 0;
  int bad   = 0;

  // Model state: sampled line words (oldest first), filtered level, strobes,
  // consecutive differing-edge streak and glitch tally per channel.
  logic [CH-1:0] m_samp[$];
  logic [CH-1:0] m_out;
  logic [CH-1:0] m_rise;
  logic [CH-1:0] m_fall;
  int            m_streak[CH];
  int            m_gc[CH];

  i2c_deb_filter_mc #(.CH(CH), .CNT_W(CNT_W), .GC_W(GC_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .line_i       (line),
    .force_low_i  (force_low),
    .thr_i        (thr),
    .glitch_clr_i (glitch_clr),
    .line_o       (line_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .glitch_cnt_o (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic [CH-1:0] syn;
    int t;
    bit gi;
    if (rst) begin
      m_samp.delete();
      m_samp.push_back('1);
      m_samp.push_back('1);
      m_out  = '1;
      m_rise = '0;
      m_fall = '0;
      for (int n = 0; n < CH; n++) begin
        m_streak[n] = 0;
        m_gc[n] = 0;
      end
    end else begin
      syn = m_samp[0];
      t = (thr == 0) ? 1 : int'(thr);
      m_rise = '0;
      m_fall = '0;
      for (int n = 0; n < CH; n++) begin
        gi = 1'b0;
        if (force_low[n]) begin
          if (m_out[n]) m_fall[n] = 1'b1;
          m_out[n] = 1'b0;
          m_streak[n] = 0;
        end else if (syn[n] != m_out[n]) begin
          m_streak[n]++;
          if (m_streak[n] >= t) begin
            m_out[n]  = syn[n];
            m_rise[n] = syn[n];
            m_fall[n] = ~syn[n];
            m_streak[n] = 0;
          end
        end else begin
          gi = (m_streak[n] > 0);
          m_streak[n] = 0;
        end
        if (glitch_clr) m_gc[n] = 0;
        else if (gi && m_gc[n] < GC_MAX) m_gc[n]++;
      end
      void'(m_samp.pop_front());
      m_samp.push_back(line);
    end
  endtask

  function automatic logic [CH*GC_W-1:0] exp_gcnt();
    logic [CH*GC_W-1:0] r;
    r = '0;
    for (int n = 0; n < CH; n++)
      if (GC_EN) r[n*GC_W +: GC_W] = GC_W'(m_gc[n]);
    return r;
  endfunction

  // One clock edge: model follows the inputs sampled at the edge; outputs settle by #1.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_l, exp_f;
    rst = 1'b1; thr = 4'd3; line = '1; force_low = '0; glitch_clr = 1'b0;
    tick(); tick();
    total++; if (line_o !== 2'b11) begin bad++; $display("FAIL reset_line: got %b want 11", line_o); end
    total++; if (rise_o !== 2'b00) begin bad++; $display("FAIL reset_rise: got %b want 00", rise_o); end
    total++; if (fall_o !== 2'b00) begin bad++; $display("FAIL reset_fall: got %b want 00", fall_o); end
    total++; if (glitch_cnt !== '0) begin bad++; $display("FAIL reset_gcnt: got %h want 0", glitch_cnt); end
    rst = 1'b0;
    tick(); tick();
    line[0] = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tick();
      exp_l = (i >= 4) ? 1'b0 : 1'b1;
      exp_f = (i == 4);
      total++; if (line_o[0] !== exp_l) begin bad++; $display("FAIL thr3_line k+%0d: got %b want %b", i, line_o[0], exp_l); end
      total++; if (fall_o[0] !== exp_f) begin bad++; $display("FAIL thr3_fall k+%0d: got %b want %b", i, fall_o[0], exp_f); end
    end
  endtask

  task automatic test_glitch_sat();
    int dropped;
    logic [GC_W-1:0] exp1;
    do_reset();
    thr = 4'd4; line = '1; force_low = '0; glitch_clr = 1'b0;
    tick(); tick(); tick();
    dropped = 0;
    for (int p = 0; p < 300; p++) begin
      line[1] = 1'b0;
      for (int j = 0; j < 3; j++) begin tick(); if (line_o[1] !== 1'b1) dropped++; end
      line[1] = 1'b1;
      for (int j = 0; j < 3; j++) begin tick(); if (line_o[1] !== 1'b1) dropped++; end
      if (p == 0) begin
        exp1 = GC_EN ? GC_W'(1) : '0;
        total++; if (glitch_cnt[GC_W +: GC_W] !== exp1) begin bad++; $display("FAIL glitch_first: got %0d want %0d", glitch_cnt[GC_W +: GC_W], exp1); end
      end
    end
    exp1 = GC_EN ? GC_W'(GC_MAX) : '0;
    total++; if (glitch_cnt[GC_W +: GC_W] !== exp1) begin bad++; $display("FAIL glitch_sat: got %0d want %0d", glitch_cnt[GC_W +: GC_W], exp1); end
    total++; if (glitch_cnt[0 +: GC_W] !== '0) begin bad++; $display("FAIL glitch_ch0: got %0d want 0", glitch_cnt[0 +: GC_W]); end
    total++; if (dropped !== 0) begin bad++; $display("FAIL glitch_leak: got %0d low cycles want 0", dropped); end
  endtask

  task automatic test_force();
    do_reset();
    thr = 4'd2; line = '1; force_low = '0; glitch_clr = 1'b0;
    tick(); tick(); tick();
    force_low[0] = 1'b1;
    tick();
    total++; if (line_o[0] !== 1'b0) begin bad++; $display("FAIL force_line: got %b want 0", line_o[0]); end
    total++; if (fall_o[0] !== 1'b1) begin bad++; $display("FAIL force_fall: got %b want 1", fall_o[0]); end
    tick();
    total++; if (fall_o[0] !== 1'b0) begin bad++; $display("FAIL force_fall_once: got %b want 0", fall_o[0]); end
    total++; if (line_o[1] !== 1'b1) begin bad++; $display("FAIL force_other_ch: got %b want 1", line_o[1]); end
    force_low[0] = 1'b0;
    tick();
    total++; if (line_o[0] !== 1'b0) begin bad++; $display("FAIL release_early: got %b want 0", line_o[0]); end
    tick();
    total++; if (line_o[0] !== 1'b1) begin bad++; $display("FAIL release_line: got %b want 1", line_o[0]); end
    total++; if (rise_o[0] !== 1'b1) begin bad++; $display("FAIL release_rise: got %b want 1", rise_o[0]); end
    tick();
    total++; if (rise_o[0] !== 1'b0) begin bad++; $display("FAIL release_rise_once: got %b want 0", rise_o[0]); end
    total++; if (glitch_cnt !== '0) begin bad++; $display("FAIL force_no_glitch: got %h want 0", glitch_cnt); end
  endtask

  task automatic test_thr0();
    logic exp_l, exp_r, exp_f;
    do_reset();
    thr = 4'd0; line = '1; force_low = '0; glitch_clr = 1'b0;
    tick(); tick();
    for (int i = 0; i <= 4; i++) begin
      line[0] = (i == 0) ? 1'b0 : 1'b1;
      tick();
      exp_l = (i == 2) ? 1'b0 : 1'b1;
      exp_f = (i == 2);
      exp_r = (i == 3);
      total++; if (line_o[0] !== exp_l) begin bad++; $display("FAIL thr0_line k+%0d: got %b want %b", i, line_o[0], exp_l); end
      total++; if (fall_o[0] !== exp_f) begin bad++; $display("FAIL thr0_fall k+%0d: got %b want %b", i, fall_o[0], exp_f); end
      total++; if (rise_o[0] !== exp_r) begin bad++; $display("FAIL thr0_rise k+%0d: got %b want %b", i, rise_o[0], exp_r); end
    end
  endtask

  task automatic test_midrun();
    int early;
    do_reset();
    thr = 4'd8; line = '1; force_low = '0; glitch_clr = 1'b0;
    tick(); tick();
    line[0] = 1'b0;
    early = 0;
    for (int i = 0; i <= 6; i++) begin tick(); if (line_o[0] !== 1'b1) early++; end
    total++; if (early !== 0) begin bad++; $display("FAIL midrun_early: got %0d low cycles want 0", early); end
    thr = 4'd3;
    tick();
    total++; if (line_o[0] !== 1'b0) begin bad++; $display("FAIL midrun_line: got %b want 0", line_o[0]); end
    total++; if (fall_o[0] !== 1'b1) begin bad++; $display("FAIL midrun_fall: got %b want 1", fall_o[0]); end
    thr = 4'd8;
    line[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++; if (line_o[0] !== 1'b0) begin bad++; $display("FAIL prereset_line: got %b want 0", line_o[0]); end
    rst = 1'b1;
    tick();
    total++; if (line_o !== 2'b11) begin bad++; $display("FAIL rst_mid_line: got %b want 11", line_o); end
    total++; if (rise_o !== 2'b00) begin bad++; $display("FAIL rst_mid_rise: got %b want 00", rise_o); end
    total++; if (fall_o !== 2'b00) begin bad++; $display("FAIL rst_mid_fall: got %b want 00", fall_o); end
    rst = 1'b0;
    tick();
    total++; if (line_o !== 2'b11 || rise_o !== 2'b00) begin bad++; $display("FAIL rst_mid_after: got line %b rise %b want 11 00", line_o, rise_o); end
  endtask

  task automatic test_clr_same_edge();
    logic [GC_W-1:0] exp1;
    do_reset();
    thr = 4'd4; line = '1; force_low = '0; glitch_clr = 1'b0;
    tick(); tick();
    exp1 = GC_EN ? GC_W'(1) : '0;
    line[1] = 1'b0; tick(); tick(); tick();
    line[1] = 1'b1; tick(); tick(); tick();
    total++; if (glitch_cnt[GC_W +: GC_W] !== exp1) begin bad++; $display("FAIL clr_pre: got %0d want %0d", glitch_cnt[GC_W +: GC_W], exp1); end
    line[1] = 1'b0; tick(); tick(); tick();
    line[1] = 1'b1; tick(); tick();
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    total++; if (glitch_cnt[GC_W +: GC_W] !== '0) begin bad++; $display("FAIL clr_same_edge: got %0d want 0", glitch_cnt[GC_W +: GC_W]); end
    line[1] = 1'b0; tick(); tick(); tick();
    line[1] = 1'b1; tick(); tick(); tick();
    total++; if (glitch_cnt[GC_W +: GC_W] !== exp1) begin bad++; $display("FAIL clr_post: got %0d want %0d", glitch_cnt[GC_W +: GC_W], exp1); end
  endtask

  task automatic test_random();
    logic [CH*GC_W-1:0] eg;
    do_reset();
    thr = 4'd3; line = '1; force_low = '0; glitch_clr = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      for (int n = 0; n < CH; n++) begin
        if ($urandom_range(0, 5) == 0) line[n] = ~line[n];
        force_low[n] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 63) == 0) thr = CNT_W'($urandom_range(0, 15));
      glitch_clr = ($urandom_range(0, 127) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      eg = exp_gcnt();
      total++; if (line_o !== m_out) begin bad++; $display("FAIL rnd_line c=%0d: got %b want %b", c, line_o, m_out); end
      total++; if (rise_o !== m_rise) begin bad++; $display("FAIL rnd_rise c=%0d: got %b want %b", c, rise_o, m_rise); end
      total++; if (fall_o !== m_fall) begin bad++; $display("FAIL rnd_fall c=%0d: got %b want %b", c, fall_o, m_fall); end
      total++; if (glitch_cnt !== eg) begin bad++; $display("FAIL rnd_gcnt c=%0d: got %h want %h", c, glitch_cnt, eg); end
    end
    rst = 1'b0; force_low = '0; glitch_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; line = '1; force_low = '0; thr = 4'd3; glitch_clr = 1'b0;
    test_reset();
    test_glitch_sat();
    test_force();
    test_thr0();
    test_midrun();
    test_clr_same_edge();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
